imem_loader: RTL and testbench

Boot-time controller that fills the instruction memory from a byte-serial host stream while the MIPS core is held in reset. It sits between an external byte source (UART or test-bench feeder) and the write port of a writable instruction memory. It parses a length header, assembles big-endian 32-bit words, issues one write per word at consecutive word addresses, and releases the core once the image is complete.

---
 rtl/imem_loader.sv | 112 +++++++++++
 tb/tb_imem_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader filling instruction memory from a byte stream
// Ports: CLK/RST (async, active-high); START begins a load from IDLE/DONE/ERROR;
// BYTE_IN/BYTE_VALID/BYTE_READY byte handshake; WE/WA/WD registered memory write;
// CPU_RST holds the core until the image is loaded; BUSY/DONE/ERR status.
// IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked in CHECK.
module imem_loader #(
  parameter int MEM_WIDTH     = 32,
  parameter int MEM_DEPTH     = 100,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [7:0]               BYTE_IN,
  input  logic                     BYTE_VALID,
  output logic                     BYTE_READY,
  output logic                     WE,
  output logic [ADDRESS_WIDTH-1:0] WA,
  output logic [MEM_WIDTH-1:0]     WD,
  output logic                     CPU_RST,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR} state_t;
`endif
  state_t state, next;
  logic [15:0] len, idx;
  logic [1:0]  cnt;
  logic [23:0] word;
  logic        xfer, start_ok;
  logic [15:0] hdr_len;
  assign hdr_len  = {len[15:8], BYTE_IN};
  assign xfer     = BYTE_VALID && BYTE_READY;
  assign start_ok = START && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= S_IDLE;
    else     state <= next;
  always_comb begin
    next       = state;
    BYTE_READY = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: next = START ? S_LEN_HI : state;
      S_LEN_HI: begin
        BYTE_READY = 1'b1;
        next       = xfer ? S_LEN_LO : state;
      end
      S_LEN_LO: begin
        BYTE_READY = 1'b1;
        next       = !xfer ? state : (hdr_len == 16'd0 || hdr_len > 16'(MEM_DEPTH)) ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        BYTE_READY = 1'b1;
        next       = (xfer && cnt == 2'd3) ? S_WRITE : state;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_WRITE: next = (idx + 16'd1 == len) ? S_CHECK : S_DATA;
      S_CHECK: begin
        BYTE_READY = 1'b1;
        next       = !xfer ? state : (BYTE_IN == csum) ? S_DONE : S_ERROR;
      end
`else
      S_WRITE: next = (idx + 16'd1 == len) ? S_DONE : S_DATA;
`endif
      default: next = S_IDLE;
    endcase
  end
  assign CPU_RST = state != S_DONE;
  assign DONE    = state == S_DONE;
  assign ERR     = state == S_ERROR;
  assign BUSY    = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      len  <= '0;
      idx  <= '0;
      cnt  <= '0;
      word <= '0;
      WE   <= 1'b0;
      WA   <= '0;
      WD   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      WE <= state == S_DATA && xfer && cnt == 2'd3;
      if (start_ok) begin
        idx <= '0;
        cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end
      if (state == S_LEN_HI && xfer) len[15:8] <= BYTE_IN;
      if (state == S_LEN_LO && xfer) len[7:0] <= BYTE_IN;
      if (state == S_DATA && xfer) begin
        word <= {word[15:0], BYTE_IN};
        cnt  <= cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ BYTE_IN;
`endif
        if (cnt == 2'd3) begin
          WA <= ADDRESS_WIDTH'(idx) << 2;
          WD <= MEM_WIDTH'({word, BYTE_IN});
        end
      end
      if (state == S_WRITE) idx <= idx + 16'd1;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
  logic        CLK = 0, RST = 0, START = 0, BYTE_VALID = 0;
  logic [7:0]  BYTE_IN = 0;
  logic        BYTE_READY, WE, CPU_RST, BUSY, DONE, ERR;
  logic [31:0] WA, WD;
  int checks = 0, errors = 0;
  int we_count = 0, ready_bad = 0;
  logic [31:0] wa_q[$], wd_q[$];

  imem_loader dut (
    .CLK(CLK), .RST(RST), .START(START), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .WE(WE), .WA(WA), .WD(WD), .CPU_RST(CPU_RST),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (WE) begin
      we_count++;
      wa_q.push_back(WA);
      wd_q.push_back(WD);
      if (BYTE_READY) ready_bad++;
    end

  task chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task send(input logic [7:0] b);
    int t;
    BYTE_IN = b;
    BYTE_VALID = 1;
    t = 0;
    while (!BYTE_READY && t < 40) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 40) begin
      errors++;
      $error("FAIL send_timeout observed=ready_low expected=ready_high");
    end
    @(negedge CLK);
  endtask

  task start_load();
    we_count = 0;
    ready_bad = 0;
    wa_q.delete();
    wd_q.delete();
    START = 1;
    @(negedge CLK);
    START = 0;
  endtask

  task wait_end();
    int t;
    BYTE_VALID = 0;
    t = 0;
    while (!DONE && !ERR && t < 40) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 40) begin
      errors++;
      $error("FAIL end_timeout observed=busy expected=done_or_err");
    end
  endtask

  initial begin
    RST = 1;
    repeat (3) @(negedge CLK);
    RST = 0;
    chk("rst_cpu_rst", CPU_RST, 1);
    chk("rst_ready", BYTE_READY, 0);
    chk("rst_we", WE, 0);
    chk("rst_wa", WA, 0);
    chk("rst_wd", WD, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    repeat (100) @(negedge CLK);
    chk("idle_cpu_rst", CPU_RST, 1);
    chk("idle_ready", BYTE_READY, 0);
    chk("idle_we_count", we_count, 0);
    chk("idle_busy_done_err", {BUSY, DONE, ERR}, 0);

    start_load();
    chk("two_busy", BUSY, 1);
    chk("two_cpu_rst", CPU_RST, 1);
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'hAC); send(8'h09); send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h88);
`endif
    wait_end();
    chk("two_done", DONE, 1);
    chk("two_err", ERR, 0);
    chk("two_cpu_rst_rel", CPU_RST, 0);
    chk("two_busy_end", BUSY, 0);
    chk("two_we_count", we_count, 2);
    chk("two_wa0", wa_q[0], 32'h0);
    chk("two_wd0", wd_q[0], 32'h20080005);
    chk("two_wa1", wa_q[1], 32'h4);
    chk("two_wd1", wd_q[1], 32'hAC090000);
    chk("two_ready_in_we", ready_bad, 0);

    start_load();
    chk("restart_done_clr", DONE, 0);
    send(8'h00); send(8'h00);
    BYTE_VALID = 0;
    chk("len0_err", ERR, 1);
    chk("len0_cpu_rst", CPU_RST, 1);
    chk("len0_busy", BUSY, 0);
    repeat (3) @(negedge CLK);
    chk("len0_we_count", we_count, 0);

    start_load();
    chk("len101_err_clr", ERR, 0);
    send(8'h00); send(8'h65);
    BYTE_VALID = 0;
    chk("len101_err", ERR, 1);
    chk("len101_cpu_rst", CPU_RST, 1);
    repeat (3) @(negedge CLK);
    chk("len101_we_count", we_count, 0);

    start_load();
    send(8'h00); send(8'h01);
    BYTE_VALID = 0;
    START = 1;
    @(negedge CLK);
    START = 0;
    foreach (wa_q[i]) wa_q[i] = wa_q[i];
    for (int i = 0; i < 4; i++) begin
      BYTE_VALID = 0;
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      send(i == 0 ? 8'hDE : i == 1 ? 8'hAD : i == 2 ? 8'hBE : 8'hEF);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    BYTE_VALID = 0;
    repeat (2) @(negedge CLK);
    send(8'h22);
`endif
    wait_end();
    chk("stall_done", DONE, 1);
    chk("stall_we_count", we_count, 1);
    chk("stall_wa", wa_q[0], 32'h0);
    chk("stall_wd", wd_q[0], 32'hDEADBEEF);

    start_load();
    send(8'h00); send(8'h02); send(8'h11); send(8'h22);
    BYTE_VALID = 0;
    RST = 1;
    #1;
    chk("midrst_we", WE, 0);
    chk("midrst_cpu_rst", CPU_RST, 1);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_ready", BYTE_READY, 0);
    @(negedge CLK);
    RST = 0;
    repeat (5) @(negedge CLK);
    chk("midrst_we_count", we_count, 0);
    chk("midrst_idle", {BUSY, DONE, ERR}, 0);
    start_load();
    send(8'h00); send(8'h01);
    send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h30);
`endif
    wait_end();
    chk("after_rst_done", DONE, 1);
    chk("after_rst_we_count", we_count, 1);
    chk("after_rst_wa", wa_q[0], 32'h0);
    chk("after_rst_wd", wd_q[0], 32'hCAFEBABE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    start_load();
    send(8'h00); send(8'h01);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h08);
    wait_end();
    chk("csum_ok_done", DONE, 1);
    chk("csum_ok_err", ERR, 0);
    start_load();
    send(8'h00); send(8'h01);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h09);
    wait_end();
    chk("csum_bad_err", ERR, 1);
    chk("csum_bad_cpu_rst", CPU_RST, 1);
    chk("csum_bad_we_count", we_count, 1);
    chk("csum_bad_wa", wa_q[0], 32'h0);
    chk("csum_bad_wd", wd_q[0], 32'h12345678);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
